// File: rtl/odo_scan_pkg.sv
// odo_scan_pkg: shared types and constants for the odometer scan transmitter.
//   state_e    - transmitter FSM states (IDLE, SHIFT, GAP), 2-bit encoding
//   PAR_BITS   - 1 when ODO_SCAN_TX_PARITY_EN is defined (trailing parity bit), else 0
//   cnt_width  - bit-counter width for a given payload width
package odo_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

`ifdef ODO_SCAN_TX_PARITY_EN
  localparam int unsigned PAR_BITS = 1;
`else
  localparam int unsigned PAR_BITS = 0;
`endif

  // Wide enough to hold DATA_W+1 without wrapping.
  function automatic int unsigned cnt_width(input int unsigned data_w);
    return $clog2(data_w + 2);
  endfunction

endpackage

// File: rtl/odo_scan_tx.sv
// odo_scan_tx: parallel-to-serial transmitter for the odometer readout path.
// Captures a DATA_W-bit word on a LOAD_VALID/LOAD_READY handshake and shifts
// it out MSB-first, one bit per CLK, followed by GAP_CYC forced idle cycles.
// Optional macro ODO_SCAN_TX_PARITY_EN appends an even-parity bit to each frame.
// Ports:
//   CLK         in   clock, posedge
//   RST_N       in   async active-low reset
//   LOAD_VALID  in   DATA_IN holds a word to transmit
//   LOAD_READY  out  word can be accepted this cycle
//   DATA_IN     in   parallel word (sampled on handshake only)
//   SHIFT_OUT   out  registered serial data
//   SHIFT_VALID out  SHIFT_OUT carries a frame bit
//   FRAME_START out  first (MSB) bit of a frame
//   BUSY        out  in SHIFT or GAP
module odo_scan_tx
  import odo_scan_pkg::*;
#(
  parameter int unsigned DATA_W  = 24,
  parameter int unsigned GAP_CYC = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              LOAD_VALID,
  output logic              LOAD_READY,
  input  logic [DATA_W-1:0] DATA_IN,
  output logic              SHIFT_OUT,
  output logic              SHIFT_VALID,
  output logic              FRAME_START,
  output logic              BUSY
);

  localparam int unsigned   CW        = cnt_width(DATA_W);
  localparam logic [CW-1:0] FRAME_LEN = CW'(DATA_W + PAR_BITS);
  localparam logic [3:0]    GAP_LEN   = 4'(GAP_CYC);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   sh_q, sh_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [3:0]          gap_q, gap_d;
  logic                out_q, out_d;
  logic                vld_q, vld_d;
  logic                fs_q, fs_d;
  logic                rdy_en_q;
  logic                load_ready;
  logic                next_bit;

`ifdef ODO_SCAN_TX_PARITY_EN
  logic par_q, par_d;
  // cnt_q==2 means the data bit on SHIFT_OUT is bit 0; parity goes next.
  assign next_bit = (cnt_q == CW'(2)) ? par_q : sh_q[DATA_W-1];
`else
  assign next_bit = sh_q[DATA_W-1];
`endif

  // rdy_en_q keeps LOAD_READY low while held in reset and until the first
  // edge after release, even though the state register already reads IDLE.
  assign load_ready  = (state_q == ST_IDLE) && rdy_en_q;
  assign LOAD_READY  = load_ready;
  assign SHIFT_OUT   = out_q;
  assign SHIFT_VALID = vld_q;
  assign FRAME_START = fs_q;
  assign BUSY        = (state_q != ST_IDLE);

  // cnt_q counts bits still to be presented, including the one on SHIFT_OUT.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    out_d   = out_q;
    vld_d   = vld_q;
    fs_d    = fs_q;
`ifdef ODO_SCAN_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        out_d = 1'b0;
        vld_d = 1'b0;
        fs_d  = 1'b0;
        if (LOAD_VALID && load_ready) begin
          state_d = ST_SHIFT;
          out_d   = DATA_IN[DATA_W-1];
          vld_d   = 1'b1;
          fs_d    = 1'b1;
          sh_d    = DATA_IN << 1;
          cnt_d   = FRAME_LEN;
`ifdef ODO_SCAN_TX_PARITY_EN
          par_d   = ^DATA_IN;
`endif
        end
      end
      ST_SHIFT: begin
        fs_d = 1'b0;
        if (cnt_q == CW'(1)) begin
          out_d = 1'b0;
          vld_d = 1'b0;
          cnt_d = '0;
          if (GAP_CYC != 0) begin
            state_d = ST_GAP;
            gap_d   = GAP_LEN;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
          out_d = next_bit;
          sh_d  = sh_q << 1;
        end
      end
      ST_GAP: begin
        out_d = 1'b0;
        vld_d = 1'b0;
        fs_d  = 1'b0;
        if (gap_q <= 4'd1) begin
          state_d = ST_IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        out_d   = 1'b0;
        vld_d   = 1'b0;
        fs_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      sh_q     <= '0;
      cnt_q    <= '0;
      gap_q    <= '0;
      out_q    <= 1'b0;
      vld_q    <= 1'b0;
      fs_q     <= 1'b0;
      rdy_en_q <= 1'b0;
`ifdef ODO_SCAN_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      out_q    <= out_d;
      vld_q    <= vld_d;
      fs_q     <= fs_d;
      rdy_en_q <= 1'b1;
`ifdef ODO_SCAN_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_odo_scan_tx.sv
// Testbench for odo_scan_tx: directed scenarios plus randomized load traffic
// and resets, checked every cycle against a frame-timeline reference model.
module tb_odo_scan_tx;

  localparam int W = 8;
  localparam int G = 2;
`ifdef ODO_SCAN_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int L = W + P;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         lv = 1'b0;
  logic [W-1:0] din = '0;
  logic         ready, sout, svalid, fstart, busy;

  logic         lv2 = 1'b0;
  logic [1:0]   din2 = '0;
  logic         ready2, sout2, svalid2, fstart2, busy2;

  int checks = 0;
  int errors = 0;

  // Reference model: t = cycle index within the current frame (1 = MSB cycle),
  // 0 = idle. rinit = at least one clock edge seen since reset release.
  int           t = 0;
  bit           rinit = 0;
  logic [W-1:0] mword = '0;

  always #5 clk = ~clk;

  odo_scan_tx #(.DATA_W(W), .GAP_CYC(G)) dut (
    .CLK(clk), .RST_N(rst_n), .LOAD_VALID(lv), .LOAD_READY(ready),
    .DATA_IN(din), .SHIFT_OUT(sout), .SHIFT_VALID(svalid),
    .FRAME_START(fstart), .BUSY(busy)
  );

  odo_scan_tx #(.DATA_W(2), .GAP_CYC(0)) dut2 (
    .CLK(clk), .RST_N(rst_n), .LOAD_VALID(lv2), .LOAD_READY(ready2),
    .DATA_IN(din2), .SHIFT_OUT(sout2), .SHIFT_VALID(svalid2),
    .FRAME_START(fstart2), .BUSY(busy2)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b (t=%0d)", tag, obs, exp, t);
    end
  endtask

  // Frame stream: positions 1..W are data MSB-first, position W+1 is parity.
  function automatic logic frame_bit(input int pos);
    if (pos <= W) return mword[W-pos];
    return ^mword;
  endfunction

  task automatic check_all();
    logic v;
    v = (t >= 1) && (t <= L);
    chk("SHIFT_VALID", svalid, v);
    chk("SHIFT_OUT",   sout,   v ? frame_bit(t) : 1'b0);
    chk("FRAME_START", fstart, t == 1);
    chk("BUSY",        busy,   t != 0);
    chk("LOAD_READY",  ready,  (t == 0) && rinit);
  endtask

  // One clock: drive inputs, advance model at posedge, check at negedge.
  task automatic step(input logic v, input logic [W-1:0] d);
    bit hs;
    lv  = v;
    din = d;
    hs  = (t == 0) && rinit && v;
    @(posedge clk);
    rinit = 1;
    if (hs) begin
      mword = d;
      t = 1;
    end else if (t != 0) begin
      t++;
      if (t > L + G) t = 0;
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic mid_reset();
    #2 rst_n = 1'b0;
    t = 0;
    rinit = 0;
    #1 check_all();
    chk("dut2 SHIFT_VALID rst", svalid2, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    #3 check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Single 8'hA5 frame, then idle out the gap
    step(1'b1, 8'hA5);
    for (int i = 0; i < 13; i++) step(1'b0, $urandom);

    // Back-to-back: valid held high, FF then 00
    step(1'b1, 8'hFF);
    for (int i = 0; i < 11; i++) step(1'b1, 8'h00);
    for (int i = 0; i < 13; i++) step(1'b0, 8'h00);

    // Load pulse during active frame is ignored
    step(1'b1, 8'hA5);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00);
    step(1'b1, 8'h3C);
    for (int i = 0; i < 14; i++) step(1'b0, 8'h3C);

    // Reset mid-frame
    step(1'b1, 8'hA5);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00);
    mid_reset();
    for (int i = 0; i < 12; i++) step(1'b0, 8'hA5);

    // Parity-relevant words
    step(1'b1, 8'h07);
    for (int i = 0; i < 12; i++) step(1'b0, 8'h00);
    step(1'b1, 8'h03);
    for (int i = 0; i < 12; i++) step(1'b0, 8'h00);

    // DATA_W=2, GAP_CYC=0 instance: load 2'b10
    lv2 = 1'b1;
    din2 = 2'b10;
    step(1'b0, 8'h00);
    chk("w2 bit1 out",   sout2,    1'b1);
    chk("w2 bit1 valid", svalid2,  1'b1);
    chk("w2 bit1 fs",    fstart2,  1'b1);
    chk("w2 bit1 ready", ready2,   1'b0);
    lv2 = 1'b0;
    din2 = 2'b01;
    step(1'b0, 8'h00);
    chk("w2 bit0 out",   sout2,    1'b0);
    chk("w2 bit0 valid", svalid2,  1'b1);
    chk("w2 bit0 fs",    fstart2,  1'b0);
`ifdef ODO_SCAN_TX_PARITY_EN
    step(1'b0, 8'h00);
    chk("w2 par out",    sout2,    1'b1);
    chk("w2 par valid",  svalid2,  1'b1);
`endif
    step(1'b0, 8'h00);
    chk("w2 end ready",  ready2,   1'b1);
    chk("w2 end valid",  svalid2,  1'b0);
    chk("w2 end busy",   busy2,    1'b0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, W'($urandom));
      if ($urandom_range(0, 80) == 0) mid_reset();
    end
    for (int i = 0; i < 13; i++) step(1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
